// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demux with a 2-entry register FIFO per output; one cycle input-to-output.
// A full output buffer deasserts s_ready only for beats selecting it; the other output keeps flowing.

module stream_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [1:0]    occ
);
    logic [DW-1:0] mem [2];
    logic          rd_ptr;
    logic          wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign dout = mem[rd_ptr];
endmodule

module stream_demux_1to2 #(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    input  logic             s_sel,
    output logic             m0_valid,
    input  logic             m0_ready,
    output logic [DW-1:0]    m0_data,
    output logic             m1_valid,
    input  logic             m1_ready,
    output logic [DW-1:0]    m1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    logic [1:0] occ0;
    logic [1:0] occ1;
    logic [1:0] occ_sel;
    logic       accept;
    logic       push0;
    logic       push1;
    logic       pop0;
    logic       pop1;

    // Full is judged on current occupancy only, so a same-cycle pop cannot make room.
    assign occ_sel = s_sel ? occ1 : occ0;
    assign s_ready = ~rst & (occ_sel != 2'd2);
    assign accept  = s_valid & s_ready;
    assign push0   = accept & ~s_sel;
    assign push1   = accept & s_sel;

    assign m0_valid = (occ0 != 2'd0);
    assign m1_valid = (occ1 != 2'd0);
    assign pop0     = m0_valid & m0_ready;
    assign pop1     = m1_valid & m1_ready;

    stream_fifo2 #(.DW(DW)) u_buf0 (
        .clk  (clk),
        .rst  (rst),
        .push (push0),
        .din  (s_data),
        .pop  (pop0),
        .dout (m0_data),
        .occ  (occ0)
    );

    stream_fifo2 #(.DW(DW)) u_buf1 (
        .clk  (clk),
        .rst  (rst),
        .push (push1),
        .din  (s_data),
        .pop  (pop1),
        .dout (m1_data),
        .occ  (occ1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0) cnt0 <= cnt0 + 1'b1;
            if (pop1) cnt1 <= cnt1 + 1'b1;
        end
    end
endmodule
